rs_issue_queue: RTL and testbench
=================================

Name: rs_issue_queue

Overview:
- Parametrised reservation station; successor to the single-port RS.
- Holds dispatched ALU/branch/jump ops until their operands are available. Wakes operands from CDB_PORTS result buses and issues the oldest ready entry to one execution unit through a valid/ready handshake.
- Adds flush, same-cycle dispatch bypass, age-ordered selection, backpressure and an occupancy count.
- Sits between dispatcher and ALU; snoops all CDB ports.

Parameters:
- DEPTH, 8: number of entries; power of two, >=2.
- DATA_W, 32: operand, immediate and result width.
- TAG_W, 4: ROB tag width. Tag 0 means "no dependency" and is never broadcast.
- OP_W, 6: internal opcode width.
- PC_W, 32: PC width.
- CDB_PORTS, 2: number of result broadcast ports, >=1.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- flush_in  in  1  misprediction flush from ROB.
- disp_valid_in  in  1  dispatch request.
- disp_ready_out  out  1  at least one free entry.
- disp_op_in  in  OP_W  opcode.
- disp_qj_in, disp_qk_in  in  TAG_W  source tags; 0 = value valid.
- disp_vj_in, disp_vk_in  in  DATA_W  source values.
- disp_imm_in  in  DATA_W  immediate.
- disp_dest_in  in  TAG_W  destination ROB tag.
- disp_pc_in  in  PC_W  instruction PC.
- cdb_valid_in  in  CDB_PORTS  per-port broadcast valid.
- cdb_tag_in  in  CDB_PORTS*TAG_W  packed tags; port p occupies bits [p*TAG_W +: TAG_W].
- cdb_value_in  in  CDB_PORTS*DATA_W  packed results, packed the same way.
- issue_valid_out  out  1  issue register holds an op.
- issue_ready_in  in  1  execution unit accepts.
- issue_op_out  out  OP_W  issued op fields.
- issue_vj_out, issue_vk_out, issue_imm_out  out  DATA_W  issued op fields.
- issue_dest_out  out  TAG_W  issued op fields.
- issue_pc_out  out  PC_W  issued op fields.
- free_count_out  out  $clog2(DEPTH+1)  registered number of free entries.

Behaviour:
- Reset (rst_in=0, async):
  - All busy bits and the age matrix are cleared.
  - issue_valid_out=0 and all issue_* data outputs=0.
  - free_count_out=DEPTH; disp_ready_out=1.
- Priority each edge: reset > rdy_in low (hold everything) > flush_in > normal operation.
- rdy_in low: CDB producers also stall, so CDB inputs are ignored.
- flush_in=1 (sync):
  - All entries freed; issue_valid_out=0.
  - free_count_out=DEPTH next cycle.
  - Dispatch and CDB in the same cycle are ignored.
- disp_ready_out = (free_count_out != 0). It is computed from registered state only and does not see a same-cycle issue.
- Dispatch fires when disp_valid_in & disp_ready_out.
  - Allocates the lowest-index free entry.
  - The entry becomes the youngest in the age matrix.
- Dispatch bypass: if disp_qj_in/disp_qk_in is nonzero and equals a valid CDB tag in the same cycle, that CDB value is stored and the tag set to 0.
- Wakeup: each busy entry compares qj and qk against every valid CDB port.
  - On a match, the value is captured and the tag zeroed.
  - Tag 0 never matches.
  - If several ports carry the same tag, the lowest port index wins.
- Ready = busy & qj==0 & qk==0, using registered tags. A wakeup at edge t makes the entry eligible from edge t+1; there is no wakeup-to-issue bypass in the same edge.
- Issue register loads when !issue_valid_out | issue_ready_in.
  - It takes the oldest ready entry per the age matrix and frees that entry the same edge.
  - If no entry is ready, issue_valid_out becomes 0 (or stays 0).
  - While issue_valid_out & !issue_ready_in, all issue_* outputs hold stable.
- Minimum latency: an op dispatched with both operands ready at edge t has issue_valid_out=1 after edge t+1.
- An entry freed by issue at edge t is allocatable from edge t+1.
- Dispatch and issue may occur in the same edge: free_count_out changes by -1, 0 or +1 accordingly.
- Full (free_count_out=0): disp_ready_out=0; disp_valid_in is ignored, with no overwrite.
- Fields the op does not use (vk for I-type, vj for LUI) are dispatched with q=0 and issued as-is.

Test Plan:
1. Reset low mid-stream with entries busy, then release → issue_valid_out=0, free_count_out=8, disp_ready_out=1 immediately, with no clock.
2. Dispatch op ADD with qj=0, vj=5, qk=0, vk=7, dest=3 at edge t, issue_ready_in=1 → issue_valid_out=1 after t+1 with vj=5, vk=7, dest=3.
3. Dispatch qj=4 at edge t; CDB port1 broadcasts tag 4, value 0x1234 at edge t+2 → entry issues after edge t+3 with vj=0x1234. Repeat with the broadcast in the dispatch cycle → issues after t+1.
4. Fill all 8 entries with unresolved tags → disp_ready_out=0 and a 9th dispatch is dropped. Resolve entries 5 and 2 (entry 2 dispatched earlier) in the same cycle → entry 2 issues first.
5. Hold issue_ready_in=0 for 3 cycles with a valid issue → outputs unchanged and no further entries freed. Raise it → the next oldest ready op loads the following edge.
6. flush_in pulsed with 6 busy entries while a dispatch and CDB hit are presented → next cycle free_count_out=8, issue_valid_out=0, no entry retained.

Source files
------------

// File: rtl/rs_issue_queue.sv
// Reservation station: holds dispatched ops until operands arrive on the CDB and issues the
// oldest ready op into a valid/ready issue register.
module rs_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OP_W      = 6,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned CDB_PORTS = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic                           disp_valid_in,
  output logic                           disp_ready_out,
  input  logic [OP_W-1:0]                disp_op_in,
  input  logic [TAG_W-1:0]               disp_qj_in,
  input  logic [TAG_W-1:0]               disp_qk_in,
  input  logic [DATA_W-1:0]              disp_vj_in,
  input  logic [DATA_W-1:0]              disp_vk_in,
  input  logic [DATA_W-1:0]              disp_imm_in,
  input  logic [TAG_W-1:0]               disp_dest_in,
  input  logic [PC_W-1:0]                disp_pc_in,
  input  logic [CDB_PORTS-1:0]           cdb_valid_in,
  input  logic [CDB_PORTS*TAG_W-1:0]     cdb_tag_in,
  input  logic [CDB_PORTS*DATA_W-1:0]    cdb_value_in,
  output logic                           issue_valid_out,
  input  logic                           issue_ready_in,
  output logic [OP_W-1:0]                issue_op_out,
  output logic [DATA_W-1:0]              issue_vj_out,
  output logic [DATA_W-1:0]              issue_vk_out,
  output logic [DATA_W-1:0]              issue_imm_out,
  output logic [TAG_W-1:0]               issue_dest_out,
  output logic [PC_W-1:0]                issue_pc_out,
  output logic [$clog2(DEPTH+1)-1:0]     free_count_out
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0]  cdb_tag [CDB_PORTS];
  logic [DATA_W-1:0] cdb_val [CDB_PORTS];

  logic [DEPTH-1:0]  busy_q, busy_d;
  // older_q[i][j] set means entry i was dispatched before entry j.
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [TAG_W-1:0]  qj_q   [DEPTH];
  logic [TAG_W-1:0]  qj_d   [DEPTH];
  logic [TAG_W-1:0]  qk_q   [DEPTH];
  logic [TAG_W-1:0]  qk_d   [DEPTH];
  logic [DATA_W-1:0] vj_q   [DEPTH];
  logic [DATA_W-1:0] vj_d   [DEPTH];
  logic [DATA_W-1:0] vk_q   [DEPTH];
  logic [DATA_W-1:0] vk_d   [DEPTH];
  logic [DATA_W-1:0] imm_q  [DEPTH];
  logic [DATA_W-1:0] imm_d  [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  dest_d [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [PC_W-1:0]   pc_d   [DEPTH];

  logic [TAG_W-1:0]  qj_w [DEPTH];
  logic [TAG_W-1:0]  qk_w [DEPTH];
  logic [DATA_W-1:0] vj_w [DEPTH];
  logic [DATA_W-1:0] vk_w [DEPTH];
  logic [TAG_W-1:0]  new_qj, new_qk;
  logic [DATA_W-1:0] new_vj, new_vk;

  logic              iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]   iss_op_q, iss_op_d;
  logic [DATA_W-1:0] iss_vj_q, iss_vj_d;
  logic [DATA_W-1:0] iss_vk_q, iss_vk_d;
  logic [DATA_W-1:0] iss_imm_q, iss_imm_d;
  logic [TAG_W-1:0]  iss_dest_q, iss_dest_d;
  logic [PC_W-1:0]   iss_pc_q, iss_pc_d;

  logic [DEPTH-1:0]  ready_vec, oldest_vec;
  logic [IDX_W-1:0]  sel_idx, alloc_idx;
  logic              any_ready, disp_fire, issue_load, issue_fire;

  always_comb begin
    for (int p = 0; p < int'(CDB_PORTS); p++) begin
      cdb_tag[p] = cdb_tag_in[p*TAG_W +: TAG_W];
      cdb_val[p] = cdb_value_in[p*DATA_W +: DATA_W];
    end
  end

  // Wakeup of stored entries and bypass of the incoming op; descending scan so the lowest
  // matching port is applied last and wins.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      qj_w[i] = qj_q[i];
      qk_w[i] = qk_q[i];
      vj_w[i] = vj_q[i];
      vk_w[i] = vk_q[i];
    end
    new_qj = disp_qj_in;
    new_qk = disp_qk_in;
    new_vj = disp_vj_in;
    new_vk = disp_vk_in;
    for (int p = int'(CDB_PORTS) - 1; p >= 0; p--) begin
      if (cdb_valid_in[p] && cdb_tag[p] != '0) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (cdb_tag[p] == qj_q[i]) begin
            qj_w[i] = '0;
            vj_w[i] = cdb_val[p];
          end
          if (cdb_tag[p] == qk_q[i]) begin
            qk_w[i] = '0;
            vk_w[i] = cdb_val[p];
          end
        end
        if (cdb_tag[p] == disp_qj_in) begin
          new_qj = '0;
          new_vj = cdb_val[p];
        end
        if (cdb_tag[p] == disp_qk_in) begin
          new_qk = '0;
          new_vk = cdb_val[p];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ready_vec[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      oldest_vec[i] = ready_vec[i];
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (ready_vec[j] && older_q[j][i]) oldest_vec[i] = 1'b0;
      end
    end
    any_ready = |ready_vec;
    sel_idx   = '0;
    alloc_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (oldest_vec[i]) sel_idx = IDX_W'(i);
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign disp_ready_out = (count_q != '0);
  assign disp_fire      = disp_valid_in && disp_ready_out;
  assign issue_load     = !iss_valid_q || issue_ready_in;
  assign issue_fire     = issue_load && any_ready;

  always_comb begin
    busy_d      = busy_q;
    older_d     = older_q;
    count_d     = count_q;
    op_d        = op_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    imm_d       = imm_q;
    dest_d      = dest_q;
    pc_d        = pc_q;
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_vj_d    = iss_vj_q;
    iss_vk_d    = iss_vk_q;
    iss_imm_d   = iss_imm_q;
    iss_dest_d  = iss_dest_q;
    iss_pc_d    = iss_pc_q;
    if (rdy_in) begin
      if (flush_in) begin
        busy_d      = '0;
        iss_valid_d = 1'b0;
        count_d     = CNT_W'(DEPTH);
      end else begin
        qj_d = qj_w;
        qk_d = qk_w;
        vj_d = vj_w;
        vk_d = vk_w;
        if (issue_load) begin
          iss_valid_d = any_ready;
          if (any_ready) begin
            iss_op_d        = op_q[sel_idx];
            iss_vj_d        = vj_q[sel_idx];
            iss_vk_d        = vk_q[sel_idx];
            iss_imm_d       = imm_q[sel_idx];
            iss_dest_d      = dest_q[sel_idx];
            iss_pc_d        = pc_q[sel_idx];
            busy_d[sel_idx] = 1'b0;
          end
        end
        if (disp_fire) begin
          busy_d[alloc_idx]  = 1'b1;
          op_d[alloc_idx]    = disp_op_in;
          qj_d[alloc_idx]    = new_qj;
          qk_d[alloc_idx]    = new_qk;
          vj_d[alloc_idx]    = new_vj;
          vk_d[alloc_idx]    = new_vk;
          imm_d[alloc_idx]   = disp_imm_in;
          dest_d[alloc_idx]  = disp_dest_in;
          pc_d[alloc_idx]    = disp_pc_in;
          older_d[alloc_idx] = '0;
          for (int j = 0; j < int'(DEPTH); j++) older_d[j][alloc_idx] = busy_q[j];
        end
        count_d = count_q - CNT_W'(disp_fire) + CNT_W'(issue_fire);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      count_q     <= CNT_W'(DEPTH);
      for (int i = 0; i < int'(DEPTH); i++) older_q[i] <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_vj_q    <= '0;
      iss_vk_q    <= '0;
      iss_imm_q   <= '0;
      iss_dest_q  <= '0;
      iss_pc_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      count_q     <= count_d;
      older_q     <= older_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_vj_q    <= iss_vj_d;
      iss_vk_q    <= iss_vk_d;
      iss_imm_q   <= iss_imm_d;
      iss_dest_q  <= iss_dest_d;
      iss_pc_q    <= iss_pc_d;
    end
  end

  // Payload is qualified by busy_q, so it needs no reset.
  always_ff @(posedge clk_in) begin
    op_q   <= op_d;
    qj_q   <= qj_d;
    qk_q   <= qk_d;
    vj_q   <= vj_d;
    vk_q   <= vk_d;
    imm_q  <= imm_d;
    dest_q <= dest_d;
    pc_q   <= pc_d;
  end

  assign issue_valid_out = iss_valid_q;
  assign issue_op_out    = iss_op_q;
  assign issue_vj_out    = iss_vj_q;
  assign issue_vk_out    = iss_vk_q;
  assign issue_imm_out   = iss_imm_q;
  assign issue_dest_out  = iss_dest_q;
  assign issue_pc_out    = iss_pc_q;
  assign free_count_out  = count_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Bench for rs_issue_queue: vector table, directed corner sequences and a random run against
// an entry-list reference model ordered by dispatch sequence number.
module tb_rs_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        flush;
  logic        d_valid;
  logic        disp_ready;
  logic [5:0]  d_op;
  logic [3:0]  d_qj, d_qk, d_dest;
  logic [31:0] d_vj, d_vk, d_imm, d_pc;
  logic [1:0]  cv;
  logic [3:0]  ct [2];
  logic [31:0] cval [2];
  logic [7:0]  cdb_tag_bus;
  logic [63:0] cdb_val_bus;
  logic        iss_valid, iss_ready;
  logic [5:0]  iss_op;
  logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
  logic [3:0]  iss_dest;
  logic [3:0]  free_count;

  int n_checks = 0;
  int n_pass   = 0;

  assign cdb_tag_bus = {ct[1], ct[0]};
  assign cdb_val_bus = {cval[1], cval[0]};

  always #5 clk = ~clk;

  rs_issue_queue dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .rdy_in         (rdy),
    .flush_in       (flush),
    .disp_valid_in  (d_valid),
    .disp_ready_out (disp_ready),
    .disp_op_in     (d_op),
    .disp_qj_in     (d_qj),
    .disp_qk_in     (d_qk),
    .disp_vj_in     (d_vj),
    .disp_vk_in     (d_vk),
    .disp_imm_in    (d_imm),
    .disp_dest_in   (d_dest),
    .disp_pc_in     (d_pc),
    .cdb_valid_in   (cv),
    .cdb_tag_in     (cdb_tag_bus),
    .cdb_value_in   (cdb_val_bus),
    .issue_valid_out(iss_valid),
    .issue_ready_in (iss_ready),
    .issue_op_out   (iss_op),
    .issue_vj_out   (iss_vj),
    .issue_vk_out   (iss_vk),
    .issue_imm_out  (iss_imm),
    .issue_dest_out (iss_dest),
    .issue_pc_out   (iss_pc),
    .free_count_out (free_count)
  );

  // Reference model: unordered slots, age given by a dispatch sequence number.
  bit          m_busy [8];
  logic [5:0]  m_op [8];
  logic [3:0]  m_qj [8], m_qk [8], m_dest [8];
  logic [31:0] m_vj [8], m_vk [8], m_imm [8], m_pc [8];
  int          m_seq [8];
  int          seq_ctr;
  bit          m_iv;
  logic [5:0]  m_i_op;
  logic [3:0]  m_i_dest;
  logic [31:0] m_i_vj, m_i_vk, m_i_imm, m_i_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_busy[i] = 0;
    m_iv = 0;
    seq_ctr = 0;
  endtask

  // Lowest CDB port carrying a nonzero matching tag supplies the value.
  task automatic resolve(input logic [3:0] q, input logic [31:0] v,
                         output logic [3:0] nq, output logic [31:0] nv);
    nq = q;
    nv = v;
    for (int p = 1; p >= 0; p--) begin
      if (cv[p] && ct[p] != 4'd0 && ct[p] == q) begin
        nq = 4'd0;
        nv = cval[p];
      end
    end
  endtask

  task automatic model_step();
    bit          bprev [8];
    int          nfree, sel, a;
    logic [3:0]  tq;
    logic [31:0] tv;
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 0;
      m_iv = 0;
      return;
    end
    bprev = m_busy;
    nfree = 0;
    for (int i = 0; i < 8; i++) if (!bprev[i]) nfree++;
    if (!m_iv || iss_ready) begin
      sel = -1;
      for (int i = 0; i < 8; i++)
        if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && (sel < 0 || m_seq[i] < m_seq[sel]))
          sel = i;
      if (sel >= 0) begin
        m_iv = 1;
        m_i_op = m_op[sel]; m_i_vj = m_vj[sel]; m_i_vk = m_vk[sel];
        m_i_imm = m_imm[sel]; m_i_dest = m_dest[sel]; m_i_pc = m_pc[sel];
        m_busy[sel] = 0;
      end else begin
        m_iv = 0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (bprev[i]) begin
        resolve(m_qj[i], m_vj[i], tq, tv); m_qj[i] = tq; m_vj[i] = tv;
        resolve(m_qk[i], m_vk[i], tq, tv); m_qk[i] = tq; m_vk[i] = tv;
      end
    end
    if (d_valid && nfree != 0) begin
      a = -1;
      for (int i = 0; i < 8; i++) if (!bprev[i] && a < 0) a = i;
      m_busy[a] = 1;
      m_op[a] = d_op; m_imm[a] = d_imm; m_dest[a] = d_dest; m_pc[a] = d_pc;
      resolve(d_qj, d_vj, tq, tv); m_qj[a] = tq; m_vj[a] = tv;
      resolve(d_qk, d_vk, tq, tv); m_qk[a] = tq; m_vk[a] = tv;
      m_seq[a] = seq_ctr++;
    end
  endtask

  task automatic cmp_model();
    int nf = 0;
    for (int i = 0; i < 8; i++) if (!m_busy[i]) nf++;
    check("model free_count", free_count, nf);
    check("model disp_ready", disp_ready, nf != 0);
    check("model issue_valid", iss_valid, m_iv);
    if (m_iv) begin
      check("model issue_op", iss_op, m_i_op);
      check("model issue_vj", iss_vj, m_i_vj);
      check("model issue_vk", iss_vk, m_i_vk);
      check("model issue_imm", iss_imm, m_i_imm);
      check("model issue_dest", iss_dest, m_i_dest);
      check("model issue_pc", iss_pc, m_i_pc);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic clear_in();
    d_valid = 0; cv = 2'b00; flush = 0; rdy = 1;
    ct[0] = 0; ct[1] = 0; cval[0] = 0; cval[1] = 0;
  endtask

  task automatic drive_disp(input logic [5:0] op, input logic [3:0] qj, input logic [31:0] vj,
                            input logic [3:0] qk, input logic [31:0] vk, input logic [31:0] imm,
                            input logic [3:0] dest, input logic [31:0] pc);
    d_valid = 1; d_op = op; d_qj = qj; d_vj = vj; d_qk = qk; d_vk = vk;
    d_imm = imm; d_dest = dest; d_pc = pc;
  endtask

  task automatic drive_cdb(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] v0,
                           input logic [3:0] t1, input logic [31:0] v1);
    cv = v; ct[0] = t0; cval[0] = v0; ct[1] = t1; cval[1] = v1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  qj;
    logic [31:0] vj;
    logic [3:0]  qk;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic [1:0]  cv;
    logic [3:0]  t0;
    logic [31:0] v0;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic [31:0] exp_vj;
    logic [31:0] exp_vk;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{6'd1, 4'd0, 32'd5, 4'd0, 32'd7, 32'd0, 4'd3, 32'h100,
                2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 32'd5, 32'd7};
    vecs[1] = '{6'd2, 4'd4, 32'd0, 4'd0, 32'h22, 32'h1, 4'd6, 32'h104,
                2'b10, 4'd0, 32'd0, 4'd4, 32'h1234, 32'h1234, 32'h22};
    vecs[2] = '{6'd3, 4'd0, 32'hA, 4'd6, 32'd0, 32'h2, 4'd7, 32'h108,
                2'b01, 4'd6, 32'hBEEF, 4'd0, 32'd0, 32'hA, 32'hBEEF};
    vecs[3] = '{6'd4, 4'd2, 32'd0, 4'd2, 32'd0, 32'h3, 4'd8, 32'h10C,
                2'b11, 4'd2, 32'h9, 4'd2, 32'h77, 32'h9, 32'h9};
    vecs[4] = '{6'd5, 4'd0, 32'd11, 4'd0, 32'd12, 32'h4, 4'd9, 32'h110,
                2'b11, 4'd0, 32'd99, 4'd0, 32'd98, 32'd11, 32'd12};
    vecs[5] = '{6'd6, 4'd7, 32'd0, 4'd5, 32'd0, 32'h5, 4'd10, 32'h114,
                2'b11, 4'd5, 32'h55, 4'd7, 32'h77, 32'h77, 32'h55};

    clear_in();
    drive_disp(0, 0, 0, 0, 0, 0, 0, 0);
    d_valid = 0;
    iss_ready = 1;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("reset free_count", free_count, 8);
    check("reset disp_ready", disp_ready, 1);
    check("reset issue_valid", iss_valid, 0);

    // Table: single op, optional same-cycle CDB bypass, issue after two edges.
    for (int k = 0; k < 6; k++) begin
      drive_disp(vecs[k].op, vecs[k].qj, vecs[k].vj, vecs[k].qk, vecs[k].vk, vecs[k].imm,
                 vecs[k].dest, vecs[k].pc);
      drive_cdb(vecs[k].cv, vecs[k].t0, vecs[k].v0, vecs[k].t1, vecs[k].v1);
      tick();
      check("vec free after dispatch", free_count, 7);
      check("vec no issue same edge", iss_valid, 0);
      clear_in();
      tick();
      check("vec issue_valid", iss_valid, 1);
      check("vec issue_op", iss_op, vecs[k].op);
      check("vec issue_vj", iss_vj, vecs[k].exp_vj);
      check("vec issue_vk", iss_vk, vecs[k].exp_vk);
      check("vec issue_dest", iss_dest, vecs[k].dest);
      check("vec issue_imm", iss_imm, vecs[k].imm);
      check("vec issue_pc", iss_pc, vecs[k].pc);
      check("vec free after issue", free_count, 8);
    end
    tick();

    // Late wakeup: broadcast two edges after dispatch.
    drive_disp(6'd7, 4'd4, 32'd0, 4'd0, 32'd1, 32'd0, 4'd5, 32'h200);
    tick();
    clear_in();
    tick();
    check("late wake not yet ready", iss_valid, 0);
    drive_cdb(2'b10, 4'd0, 32'd0, 4'd4, 32'h1234);
    tick();
    check("late wake no same-edge issue", iss_valid, 0);
    clear_in();
    tick();
    check("late wake issue_valid", iss_valid, 1);
    check("late wake issue_vj", iss_vj, 32'h1234);
    tick();

    // Fill all eight entries with unresolved sources, then overflow.
    iss_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drive_disp(6'(i), 4'(i + 1), 32'd0, 4'd0, 32'(i), 32'(i), 4'(i + 8), 32'(i * 4));
      tick();
    end
    check("full free_count", free_count, 0);
    check("full disp_ready", disp_ready, 0);
    drive_disp(6'd63, 4'd0, 32'hDEAD, 4'd0, 32'd0, 32'd0, 4'd1, 32'h300);
    tick();
    check("overflow dropped", free_count, 0);
    clear_in();
    drive_cdb(2'b11, 4'd6, 32'h66, 4'd3, 32'h33);
    tick();
    check("resolve no same-edge issue", iss_valid, 0);
    clear_in();
    tick();
    check("oldest issued dest", iss_dest, 4'd10);
    check("oldest issued vj", iss_vj, 32'h33);
    check("one entry freed", free_count, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall issue_valid", iss_valid, 1);
      check("stall issue_dest", iss_dest, 4'd10);
      check("stall issue_vj", iss_vj, 32'h33);
      check("stall free_count", free_count, 1);
    end
    iss_ready = 1;
    tick();
    check("next oldest dest", iss_dest, 4'd13);
    check("next oldest vj", iss_vj, 32'h66);
    check("after release free", free_count, 2);
    tick();
    check("drained issue_valid", iss_valid, 0);

    // Flush with six busy, plus a dispatch and CDB hit presented.
    flush = 1;
    drive_disp(6'd9, 4'd0, 32'd1, 4'd0, 32'd2, 32'd0, 4'd2, 32'h400);
    drive_cdb(2'b01, 4'd1, 32'd5, 4'd0, 32'd0);
    tick();
    check("flush free_count", free_count, 8);
    check("flush issue_valid", iss_valid, 0);
    clear_in();
    drive_cdb(2'b11, 4'd1, 32'd1, 4'd4, 32'd4);
    tick();
    clear_in();
    tick();
    check("flush retained nothing", iss_valid, 0);
    check("flush free stays", free_count, 8);

    // Asynchronous reset mid-stream.
    iss_ready = 0;
    drive_disp(6'd11, 4'd0, 32'h11, 4'd0, 32'h22, 32'h33, 4'd6, 32'h500);
    tick();
    drive_disp(6'd12, 4'd9, 32'd0, 4'd0, 32'd0, 32'd0, 4'd7, 32'h504);
    tick();
    drive_disp(6'd13, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0, 4'd8, 32'h508);
    tick();
    clear_in();
    #2 rst_n = 0;
    model_reset();
    #1;
    check("async reset issue_valid", iss_valid, 0);
    check("async reset free_count", free_count, 8);
    check("async reset disp_ready", disp_ready, 1);
    check("async reset issue_dest", iss_dest, 0);
    check("async reset issue_vj", iss_vj, 0);
    @(posedge clk);
    #1 rst_n = 1;
    cmp_model();

    // Random run against the model.
    for (int c = 0; c < 400; c++) begin
      rdy   = ($urandom_range(0, 19) != 0);
      flush = ($urandom_range(0, 49) == 0);
      iss_ready = ($urandom_range(0, 3) != 0);
      d_valid = ($urandom_range(0, 3) != 0);
      d_op   = 6'($urandom);
      d_qj   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
      d_qk   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
      d_vj   = $urandom;
      d_vk   = $urandom;
      d_imm  = $urandom;
      d_dest = 4'($urandom);
      d_pc   = $urandom;
      cv     = 2'($urandom);
      ct[0]  = 4'($urandom_range(0, 7));
      ct[1]  = 4'($urandom_range(0, 7));
      cval[0] = $urandom;
      cval[1] = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
